// File: rtl/dilution_tree_sequencer.sv
// Valve/pump sequencer for a programmable serial-dilution cascade: per-level
// fill/mix/transfer, then reagent add and final mix across the selected channels.
module dilution_tree_sequencer #(
  parameter int LEVELS   = 6,
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [LEVELS-1:0]   level_mask,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic [CNT_W-1:0]    fill_cycles,
  input  logic [CNT_W-1:0]    mix_cycles,
  input  logic [CNT_W-1:0]    xfer_cycles,
  output logic [LEVELS-1:0]   fill_en,
  output logic [LEVELS-1:0]   mix_en,
  output logic [LEVELS-1:0]   xfer_en,
  output logic [CHANNELS-1:0] reagent_en,
  output logic                final_mix_en,
  output logic                busy,
  output logic [3:0]          cur_level,
  output logic                done,
  output logic                aborted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_MIX, S_XFER, S_REAGENT, S_FMIX, S_DONE, S_ABORT
  } state_t;

  state_t              state, state_nx, tgt, first_ph, tail_ph;
  logic [3:0]          lvl, lvl_nx, tgt_lvl;
  logic [CNT_W-1:0]    cnt, cnt_nx, tgt_dur;
  logic [LEVELS-1:0]   lmask;
  logic [CHANNELS-1:0] cmask;
  logic [CNT_W-1:0]    f_dur, m_dur, x_dur;
  logic                go, any_dur;
  logic [4:0]          hit;

  // Lowest set mask bit at or above 'from'; bit 4 flags a hit.
  function automatic logic [4:0] find_set(input logic [LEVELS-1:0] m, input logic [4:0] from);
    logic [4:0] r;
    r = '0;
    for (int i = LEVELS-1; i >= 0; i--)
      if (m[i] && 5'(i) >= from) r = {1'b1, 4'(i)};
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] dur_of(input state_t s);
    case (s)
      S_FILL, S_REAGENT: dur_of = f_dur;
      S_MIX, S_FMIX:     dur_of = m_dur;
      S_XFER:            dur_of = x_dur;
      default:           dur_of = '0;
    endcase
  endfunction

  // Zero-length phases and levels are searched past in the same cycle.
  always_comb begin
    any_dur  = (f_dur != '0) || (m_dur != '0) || (x_dur != '0);
    first_ph = (f_dur != '0) ? S_FILL : (m_dur != '0) ? S_MIX : S_XFER;
    tail_ph  = (cmask == '0) ? S_DONE :
               (f_dur != '0) ? S_REAGENT : (m_dur != '0) ? S_FMIX : S_DONE;
    hit      = find_set(lmask, (state == S_IDLE) ? 5'd0 : {1'b0, lvl} + 5'd1);
    tgt_lvl  = lvl;
    if (hit[4] && any_dur) begin
      tgt     = first_ph;
      tgt_lvl = hit[3:0];
    end else begin
      tgt     = tail_ph;
      tgt_lvl = 4'd0;
    end
    case (state)
      S_FILL: if (m_dur != '0) begin tgt = S_MIX; tgt_lvl = lvl; end
              else if (x_dur != '0) begin tgt = S_XFER; tgt_lvl = lvl; end
      S_MIX:  if (x_dur != '0) begin tgt = S_XFER; tgt_lvl = lvl; end
      S_REAGENT: begin tgt = (m_dur != '0) ? S_FMIX : S_DONE; tgt_lvl = 4'd0; end
      S_FMIX:    begin tgt = S_DONE; tgt_lvl = 4'd0; end
      default: ;
    endcase
    tgt_dur = dur_of(tgt);
  end

  always_comb begin
    state_nx = state;
    lvl_nx   = lvl;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (go) begin
        state_nx = tgt;
        lvl_nx   = tgt_lvl;
        cnt_nx   = (tgt_dur == '0) ? '0 : tgt_dur - CNT_W'(1);
      end
      S_FILL, S_MIX, S_XFER, S_REAGENT, S_FMIX: begin
        if (abort) begin
          state_nx = S_ABORT;
          lvl_nx   = 4'd0;
        end else if (cnt == '0) begin
          state_nx = tgt;
          lvl_nx   = tgt_lvl;
          cnt_nx   = (tgt_dur == '0) ? '0 : tgt_dur - CNT_W'(1);
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        lvl_nx   = 4'd0;
      end
    endcase
  end

  // Config is captured on start; the sequence launches from it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      lvl   <= '0;
      cnt   <= '0;
      go    <= 1'b0;
      lmask <= '0;
      cmask <= '0;
      f_dur <= '0;
      m_dur <= '0;
      x_dur <= '0;
    end else begin
      state <= state_nx;
      lvl   <= lvl_nx;
      cnt   <= cnt_nx;
      go    <= (state == S_IDLE) && !go && start;
      if ((state == S_IDLE) && !go && start) begin
        lmask <= level_mask;
        cmask <= chan_mask;
        f_dur <= fill_cycles;
        m_dur <= mix_cycles;
        x_dur <= xfer_cycles;
      end
    end
  end

  // Outputs registered from the next state so valves switch cleanly on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_en      <= '0;
      mix_en       <= '0;
      xfer_en      <= '0;
      reagent_en   <= '0;
      final_mix_en <= 1'b0;
      busy         <= 1'b0;
      cur_level    <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      fill_en      <= (state_nx == S_FILL) ? LEVELS'(1) << lvl_nx : '0;
      mix_en       <= (state_nx == S_MIX)  ? LEVELS'(1) << lvl_nx : '0;
      xfer_en      <= (state_nx == S_XFER) ? LEVELS'(1) << lvl_nx : '0;
      reagent_en   <= (state_nx == S_REAGENT) ? cmask : '0;
      final_mix_en <= (state_nx == S_FMIX);
      busy         <= (state_nx != S_IDLE);
      cur_level    <= (state_nx inside {S_FILL, S_MIX, S_XFER}) ? lvl_nx : 4'd0;
      done         <= (state_nx == S_DONE);
      aborted      <= (state_nx == S_ABORT);
    end
  end

endmodule

// File: tb/tb_dilution_tree_sequencer.sv
// Directed bench for dilution_tree_sequencer: full walk, level skip, zero
// durations, empty masks, abort and asynchronous reset.
module tb_dilution_tree_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [5:0]  level_mask = '0;
  logic [7:0]  chan_mask = '0;
  logic [15:0] fill_cycles = '0, mix_cycles = '0, xfer_cycles = '0;
  logic [5:0]  fill_en, mix_en, xfer_en;
  logic [7:0]  reagent_en;
  logic        final_mix_en, busy, done, aborted;
  logic [3:0]  cur_level;
  logic [33:0] obs;
  int          n_cmp = 0, n_bad = 0;

  dilution_tree_sequencer #(.LEVELS(6), .CHANNELS(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .level_mask(level_mask), .chan_mask(chan_mask),
    .fill_cycles(fill_cycles), .mix_cycles(mix_cycles), .xfer_cycles(xfer_cycles),
    .fill_en(fill_en), .mix_en(mix_en), .xfer_en(xfer_en), .reagent_en(reagent_en),
    .final_mix_en(final_mix_en), .busy(busy), .cur_level(cur_level),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  assign obs = {fill_en, mix_en, xfer_en, reagent_en, final_mix_en, busy, cur_level, done, aborted};

  function automatic logic [33:0] ex(input logic [5:0] f, input logic [5:0] m, input logic [5:0] x,
                                     input logic [7:0] r, input logic fm, input logic b,
                                     input logic [3:0] cl, input logic d, input logic a);
    return {f, m, x, r, fm, b, cl, d, a};
  endfunction

  task automatic kick(input logic [5:0] lm, input logic [7:0] cm,
                      input logic [15:0] f, input logic [15:0] m, input logic [15:0] x);
    level_mask = lm; chan_mask = cm; fill_cycles = f; mix_cycles = m; xfer_cycles = x;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if (obs !== 34'd0) begin n_bad++; $display("FAIL reset_async got %h want %h", obs, 34'd0); end
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 34'd0) begin n_bad++; $display("FAIL reset_clocked got %h want %h", obs, 34'd0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 34'd0) begin n_bad++; $display("FAIL reset_idle got %h want %h", obs, 34'd0); end
  endtask

  task automatic test_default;
    logic [33:0] e;
    int p, lv, ph;
    logic [5:0] oh;
    kick(6'b111111, 8'hFF, 16'd2, 16'd2, 16'd2);
    for (int c = 1; c <= 42; c++) begin
      @(posedge clk); #1;
      if (c <= 36) begin
        p = (c - 1) / 2; lv = p / 3; ph = p % 3;
        oh = 6'(1 << lv);
        e = ex(ph == 0 ? oh : 6'd0, ph == 1 ? oh : 6'd0, ph == 2 ? oh : 6'd0,
               8'h00, 1'b0, 1'b1, 4'(lv), 1'b0, 1'b0);
      end else if (c <= 38) e = ex(0, 0, 0, 8'hFF, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      else if (c <= 40)     e = ex(0, 0, 0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      else if (c == 41)     e = ex(0, 0, 0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      else                  e = 34'd0;
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL default cyc %0d got %h want %h", c, obs, e); end
    end
  endtask

  task automatic test_level_skip;
    logic [33:0] e;
    int lvs[3] = '{0, 1, 5};
    int lv, ph;
    logic [5:0] oh;
    kick(6'b100011, 8'h00, 16'd1, 16'd1, 16'd1);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c <= 9) begin
        lv = lvs[(c - 1) / 3]; ph = (c - 1) % 3;
        oh = 6'(1 << lv);
        e = ex(ph == 0 ? oh : 6'd0, ph == 1 ? oh : 6'd0, ph == 2 ? oh : 6'd0,
               8'h00, 1'b0, 1'b1, 4'(lv), 1'b0, 1'b0);
      end else if (c == 10) e = ex(0, 0, 0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      else                  e = 34'd0;
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL level_skip cyc %0d got %h want %h", c, obs, e); end
    end
  endtask

  task automatic test_zero_dur;
    logic [33:0] e;
    kick(6'b000001, 8'hFF, 16'd3, 16'd0, 16'd3);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c <= 3)       e = ex(6'd1, 0, 0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      else if (c <= 6)  e = ex(0, 0, 6'd1, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      else if (c <= 9)  e = ex(0, 0, 0, 8'hFF, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      else if (c == 10) e = ex(0, 0, 0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      else              e = 34'd0;
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL zero_dur cyc %0d got %h want %h", c, obs, e); end
    end
  endtask

  task automatic test_empty;
    logic [33:0] e;
    kick(6'b000000, 8'h00, 16'd2, 16'd2, 16'd2);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      e = (c == 1) ? ex(0, 0, 0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0) : 34'd0;
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL empty cyc %0d got %h want %h", c, obs, e); end
    end
  endtask

  task automatic test_abort;
    logic [33:0] e;
    kick(6'b111111, 8'hFF, 16'd2, 16'd2, 16'd2);
    repeat (15) begin @(posedge clk); #1; end
    e = ex(0, 6'b000100, 0, 8'h00, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_pre got %h want %h", obs, e); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    e = ex(0, 0, 0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_pulse got %h want %h", obs, e); end
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 34'd0) begin n_bad++; $display("FAIL abort_idle got %h want %h", obs, 34'd0); end
  endtask

  task automatic test_reset_xfer;
    logic [33:0] e;
    kick(6'b000001, 8'h00, 16'd3, 16'd3, 16'd3);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        // Competing start while busy must not disturb the running sequence.
        level_mask = 6'b111111; chan_mask = 8'hFF; fill_cycles = 16'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c <= 3)      e = ex(6'd1, 0, 0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      else if (c <= 6) e = ex(0, 6'd1, 0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      else             e = ex(0, 0, 6'd1, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL busy_start cyc %0d got %h want %h", c, obs, e); end
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 34'd0) begin n_bad++; $display("FAIL reset_xfer got %h want %h", obs, 34'd0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 34'd0) begin n_bad++; $display("FAIL reset_recover got %h want %h", obs, 34'd0); end
  endtask

  initial begin
    test_reset;
    test_default;
    test_level_skip;
    test_zero_dur;
    test_empty;
    test_abort;
    test_default;
    test_reset_xfer;
    test_zero_dur;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/dilution_tree_sequencer.md
# dilution_tree_sequencer

- Sequences the valve enables for a parametrised serial-dilution cascade.
- The cascade has LEVELS dilutor stages and CHANNELS final reagent mixers. At each enabled level the block runs a fill, mix and transfer phase, then runs a reagent-add and final-mix phase across the enabled output channels.
- It is the control-side successor to our fixed structural protein dilution trees. Depth, level skipping (e.g. C/16 straight to C/128), channel selection and phase timing are run-time programmable.

## Interface
Parameters:
- LEVELS, 6, number of dilution levels (1..16)
- CHANNELS, 8, number of final reagent mixers (1..32)
- CNT_W, 16, width of phase-duration counters

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- abort  in  1  stop sequence; takes effect in any non-IDLE state
- level_mask  in  LEVELS  levels to run; bit L=1 runs level L
- chan_mask  in  CHANNELS  reagent channels to drive
- fill_cycles  in  CNT_W  fill duration; 0 skips the phase
- mix_cycles  in  CNT_W  mix duration; 0 skips the phase
- xfer_cycles  in  CNT_W  transfer duration; 0 skips the phase
- fill_en  out  LEVELS  buffer-inlet valve per level
- mix_en  out  LEVELS  mixer pump per level
- xfer_en  out  LEVELS  transfer valve from level L onward
- reagent_en  out  CHANNELS  reagent-inlet valves
- final_mix_en  out  1  final mixer pumps (all channels)
- busy  out  1  high in every state except IDLE
- cur_level  out  4  index of the level in progress; 0 when not in a level phase
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort

## Operation
- States: IDLE, FILL, MIX, XFER, REAGENT, FMIX, DONE, ABORT.
- In IDLE with start=1, the block latches level_mask, chan_mask and the three durations. The inputs are not re-sampled until the next start.
- start during busy is ignored.
- The level pointer advances to the lowest set bit of the latched level_mask. If no bit is set, the sequence goes straight to the reagent phase.
- Per-level order is FILL → MIX → XFER, then on to the next set mask bit above the current one. After the highest set bit, the sequence goes to REAGENT.
- Phase outputs during a level phase:
  - FILL: fill_en[L]=1
  - MIX: mix_en[L]=1
  - XFER: xfer_en[L]=1
  - All other level-output bits are 0. Exactly one level output is high at a time.
- REAGENT drives reagent_en = latched chan_mask for fill_cycles cycles.
- FMIX drives final_mix_en=1 for mix_cycles cycles.
- If the latched chan_mask is 0, both REAGENT and FMIX are skipped.
- A phase with a duration of 0 is skipped entirely; it costs no cycles.
- Phase counter:
  - Loaded with duration-1 on phase entry.
  - The phase exits on the cycle the counter reads 0.
  - The counter never wraps.
- DONE lasts one cycle with done=1, then returns to IDLE.
- Abort:
  - abort=1 in any busy state gives ABORT on the next edge.
  - In ABORT, all valve and pump outputs are 0 and aborted=1 for one cycle; the next state is IDLE.
  - abort has priority over a simultaneous phase completion.
  - abort in IDLE, DONE or ABORT has no effect.
- Reset: state=IDLE, all outputs 0, latched config cleared. Reset asserted mid-sequence de-energises every valve immediately, because of the asynchronous reset.

## Timing
- All outputs are registered (Moore outputs, glitch-free valve drive).
- Start latency: start at edge 0 → first active phase output high from edge 1.
- A phase of duration N holds its enable for exactly N cycles.
- Consecutive phases are back-to-back with no idle gap. The same cycle shows the old enable deasserted and the new one asserted.
- Skipped phases and skipped levels cost 0 cycles; the next-phase search is combinational over the latched mask.
- Total cycles from start to done pulse = 1 + Σ over set levels (F+M+X) + (chan_mask≠0 ? F+M : 0). done is high in that final cycle.
- busy rises the edge after start and falls the edge after DONE or ABORT.

## Test plan
- Default run: LEVELS=6, mask=6'b111111, chan_mask=8'hFF, F=M=X=2.
  - Expect the fill_en/mix_en/xfer_en walk through levels 0..5, each high for 2 cycles, then reagent_en=8'hFF for 2 cycles and final_mix_en for 2 cycles.
  - done pulses at cycle 1+36+4=41 after start.
- Level skip: mask=6'b100011.
  - Expect only levels 0, 1 and 5 to activate; cur_level sequence 0, 1, 5; no enable on levels 2..4.
- Zero durations: M=0, F=X=3, mask=6'b000001.
  - Expect no mix_en and no final_mix_en; fill 3 cycles, xfer 3, reagent 3; done at cycle 10.
- Empty masks: mask=0, chan_mask=0.
  - Expect busy for exactly one cycle (DONE) with done=1 and no valve activity.
- Abort mid-MIX at level 2.
  - Expect mix_en[2] to drop the next edge, aborted pulse for 1 cycle, then IDLE.
  - A later start runs a full sequence correctly.
- Async reset during XFER.
  - Expect all outputs to drop to 0 without a clock edge; start during busy is ignored.
